param_mod_counter: RTL and testbench

Parametrised up/down modulo counter core for the next-generation counter designs. Adds the following over the fixed 8-bit free-running counter:
- configurable width and modulus
- direction control
- synchronous load
- one-shot mode with start/busy handshake
- terminal-count pulse
- registered output-invert toggle
It is instantiated inside a tt_um_* top that maps the ports onto ui_in/uo_out/uio_*.

---
 rtl/param_mod_counter_if.sv | 27 ++
 rtl/param_mod_counter.sv | 153 +++++++++++++++
 tb/tb_param_mod_counter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_mod_counter_if.sv
// Control/status bundle for param_mod_counter.
// The master drives the controls and the slave (the counter) returns the count and status.
interface param_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             oneshot;
  logic             start;
  logic             inv_toggle;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             busy;

  modport master (
    output en, up, load, load_val, oneshot, start, inv_toggle,
    input  count, count_out, tc, busy
  );

  modport slave (
    input  en, up, load, load_val, oneshot, start, inv_toggle,
    output count, count_out, tc, busy
  );
endinterface

// File: rtl/param_mod_counter.sv
// Up/down modulo counter with load, one-shot run mode, terminal-count pulse and output invert.
// Optional step prescaler enabled by defining PARAM_MOD_COUNTER_PRESCALER_EN.
module param_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  param_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [1:0]       sync_q;
  logic             run_en;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             busy_q;
  logic             inv_q;
  state_t           state_q;

  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic             at_wrap;
  logic             step_tick;
  logic             start_accept;

  // Reset release is synchronised; nothing moves until the second flop has seen it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run_en = sync_q[1];

  always_comb begin
    count_inc    = (count_q == MAX_W) ? '0 : count_q + WIDTH'(1);
    count_dec    = (count_q == '0) ? MAX_W : count_q - WIDTH'(1);
    step_val     = bus.up ? count_inc : count_dec;
    at_wrap      = bus.up ? (count_q == MAX_W) : (count_q == '0);
    load_clamped = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
  end

  assign start_accept = bus.oneshot && !bus.load && bus.start && (state_q != ST_RUN);

`ifdef PARAM_MOD_COUNTER_PRESCALER_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (run_en) begin
      if (bus.load || start_accept) begin
        pre_q <= '0;
      end else if (bus.en) begin
        pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      end
    end
  end

  assign step_tick = bus.en && (pre_q == PRE_LAST);
`else
  assign step_tick = bus.en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      inv_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else if (run_en) begin
      tc_q <= 1'b0;
      if (bus.inv_toggle) begin
        inv_q <= ~inv_q;
      end

      if (!bus.oneshot) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        if (bus.load) begin
          count_q <= load_clamped;
        end else if (step_tick) begin
          count_q <= step_val;
          tc_q    <= at_wrap;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.load) begin
              count_q <= load_clamped;
            end else if (bus.start) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end

          // A wrapping step saturates instead: count already sits at the end value.
          ST_RUN: begin
            if (bus.load) begin
              count_q <= load_clamped;
            end else if (step_tick) begin
              if (at_wrap) begin
                tc_q    <= 1'b1;
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
              end else begin
                count_q <= step_val;
              end
            end
          end

          ST_DONE: begin
            if (bus.load) begin
              count_q <= load_clamped;
            end else if (bus.start) begin
              count_q <= bus.up ? '0 : MAX_W;
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.count_out = count_q ^ {WIDTH{inv_q}};
  assign bus.tc        = tc_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_param_mod_counter.sv
// Bench for param_mod_counter: directed literal checks followed by randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_param_mod_counter;

  localparam int W   = 8;
  localparam int MAX = 9;
  localparam int PRE = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   cmp_en;

  int   m_count;
  int   m_tc;
  int   m_inv;
  int   m_phase;
  int   m_sync;
  int   m_pre;

  param_mod_counter_if #(.WIDTH(W)) bus ();

  param_mod_counter #(
    .WIDTH   (W),
    .MAX_VAL (MAX),
    .PRESCALE(PRE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: modular arithmetic on integers plus a three-phase one-shot run.
  initial begin
    int  nxt;
    bit  wrapping;
    bit  stepnow;
    bit  start_ok;
    int  lv;
    m_count = 0; m_tc = 0; m_inv = 0; m_phase = PH_IDLE; m_sync = 0; m_pre = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_count = 0; m_tc = 0; m_inv = 0; m_phase = PH_IDLE; m_sync = 0; m_pre = 0;
      end else if (m_sync < 2) begin
        m_sync++;
      end else begin
        m_tc = 0;
        if (bus.inv_toggle) m_inv = 1 - m_inv;
        start_ok = bus.oneshot && !bus.load && bus.start && (m_phase != PH_RUN);
`ifdef PARAM_MOD_COUNTER_PRESCALER_EN
        stepnow = bus.en && (m_pre == PRE - 1);
        if (bus.load || start_ok) m_pre = 0;
        else if (bus.en) m_pre = (m_pre + 1) % PRE;
`else
        stepnow = bus.en;
`endif
        nxt      = bus.up ? (m_count + 1) % (MAX + 1) : (m_count + MAX) % (MAX + 1);
        wrapping = bus.up ? (m_count == MAX) : (m_count == 0);
        lv       = int'(bus.load_val);
        if (!bus.oneshot) m_phase = PH_IDLE;
        if (bus.load) begin
          m_count = (lv > MAX) ? MAX : lv;
        end else if (!bus.oneshot) begin
          if (stepnow) begin
            m_tc    = wrapping ? 1 : 0;
            m_count = nxt;
          end
        end else if (m_phase == PH_IDLE) begin
          if (bus.start) m_phase = PH_RUN;
        end else if (m_phase == PH_RUN) begin
          if (stepnow) begin
            if (wrapping) begin
              m_tc    = 1;
              m_phase = PH_DONE;
            end else begin
              m_count = nxt;
            end
          end
        end else begin
          if (bus.start) begin
            m_count = bus.up ? 0 : MAX;
            m_phase = PH_RUN;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_count", 32'(bus.count), 32'(m_count));
        check("cyc_count_out", 32'(bus.count_out), 32'(m_inv ? (m_count ^ 8'hFF) : m_count));
        check("cyc_tc", 32'(bus.tc), 32'(m_tc));
        check("cyc_busy", 32'(bus.busy), 32'(m_phase == PH_RUN ? 1 : 0));
      end
    end
  end

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.oneshot = 1'b0; bus.start = 1'b0; bus.inv_toggle = 1'b0;

    repeat (3) cyc();
    cmp_en = 1'b1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_count_out", 32'(bus.count_out), 32'd0);
    check("rst_tc", 32'(bus.tc), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

`ifndef PARAM_MOD_COUNTER_PRESCALER_EN
    // Free-run up through the wrap.
    bus.en = 1'b1; bus.up = 1'b1;
    rst_n = 1'b1;
    cyc(); cyc();
    check("sync_hold", 32'(bus.count), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check("up_count", 32'(bus.count), 32'(k));
      check("up_tc", 32'(bus.tc), 32'd0);
    end
    cyc();
    check("wrap_count", 32'(bus.count), 32'd0);
    check("wrap_tc", 32'(bus.tc), 32'd1);
    cyc();
    check("post_wrap_count", 32'(bus.count), 32'd1);
    check("post_wrap_tc", 32'(bus.tc), 32'd0);

    // Down wrap, then clamped load.
    bus.up = 1'b0;
    cyc();
    check("down_count", 32'(bus.count), 32'd0);
    cyc();
    check("down_wrap_count", 32'(bus.count), 32'd9);
    check("down_wrap_tc", 32'(bus.tc), 32'd1);
    bus.load = 1'b1; bus.load_val = 8'd200;
    cyc();
    check("clamp_count", 32'(bus.count), 32'd9);
    check("clamp_tc", 32'(bus.tc), 32'd0);
    check("model_clamp", 32'(m_count), 32'd9);

    // One-shot run to saturation, then restart.
    bus.oneshot = 1'b1; bus.load_val = 8'd0; bus.up = 1'b1;
    cyc();
    check("os_load_count", 32'(bus.count), 32'd0);
    check("os_idle_busy", 32'(bus.busy), 32'd0);
    bus.load = 1'b0; bus.start = 1'b1;
    cyc();
    check("os_start_count", 32'(bus.count), 32'd0);
    check("os_start_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check("os_run_count", 32'(bus.count), 32'(k));
      check("os_run_busy", 32'(bus.busy), 32'd1);
    end
    cyc();
    check("os_sat_count", 32'(bus.count), 32'd9);
    check("os_sat_tc", 32'(bus.tc), 32'd1);
    check("os_done_busy", 32'(bus.busy), 32'd0);
    check("model_done", 32'(m_phase), 32'(PH_DONE));
    cyc();
    check("os_hold_count", 32'(bus.count), 32'd9);
    check("os_hold_tc", 32'(bus.tc), 32'd0);
    bus.start = 1'b1;
    cyc();
    check("os_restart_count", 32'(bus.count), 32'd0);
    check("os_restart_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;

    // Pause mid-run, then asynchronous reset.
    repeat (4) cyc();
    check("os_mid_count", 32'(bus.count), 32'd4);
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("os_pause_count", 32'(bus.count), 32'd4);
      check("os_pause_busy", 32'(bus.busy), 32'd1);
    end
    bus.en = 1'b1;
    cyc();
    check("os_resume_count", 32'(bus.count), 32'd5);
`endif

    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_tc", 32'(bus.tc), 32'd0);
    cyc();
    bus.oneshot = 1'b0; bus.en = 1'b0; bus.start = 1'b0;
    rst_n = 1'b1;
    cyc(); cyc();

    // Output invert toggle.
    bus.load = 1'b1; bus.load_val = 8'd5;
    cyc();
    check("inv_load_count", 32'(bus.count), 32'd5);
    check("inv_off_out", 32'(bus.count_out), 32'h05);
    bus.load = 1'b0; bus.inv_toggle = 1'b1;
    cyc();
    check("inv_on_out", 32'(bus.count_out), 32'hFA);
    cyc();
    check("inv_back_out", 32'(bus.count_out), 32'h05);
    bus.inv_toggle = 1'b0;
    cyc();
    check("inv_stay_out", 32'(bus.count_out), 32'h05);

`ifdef PARAM_MOD_COUNTER_PRESCALER_EN
    bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b1; bus.load_val = 8'd0;
    cyc();
    bus.load = 1'b0;
    repeat (3) cyc();
    check("pre_hold_count", 32'(bus.count), 32'd0);
    cyc();
    check("pre_step_count", 32'(bus.count), 32'd1);
    repeat (2) cyc();
    bus.load = 1'b1; bus.load_val = 8'd7;
    cyc();
    bus.load = 1'b0;
    repeat (3) cyc();
    check("pre_restart_hold", 32'(bus.count), 32'd7);
    cyc();
    check("pre_restart_step", 32'(bus.count), 32'd8);
`endif

    // Randomized traffic; the negedge process compares against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      bus.en         = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) bus.up = ~bus.up;
      if ($urandom_range(0, 49) == 0) bus.oneshot = ~bus.oneshot;
      bus.load       = ($urandom_range(0, 24) == 0);
      bus.load_val   = 8'($urandom_range(0, 255));
      bus.start      = ($urandom_range(0, 9) == 0);
      bus.inv_toggle = ($urandom_range(0, 9) == 0);
      cyc();
    end

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
